pe_row_feeder: RTL and testbench
================================

# pe_row_feeder

Sequencer and transmitter that drives one `PE_ROW_6` column array and collects its results. It streams PE_DIM weight vectors into the PE columns one at a time, then broadcasts compressed feature beats with their non-zero addresses and counts. After the last beat it issues `done`, waits until every column has reported `out_vd`, and hands the captured partial sums to the output buffer over a valid/ready handshake. It sits between the feature/weight buffers and the PE row.

## Interface
- MAC_DIM, 6, non-zero address slots per beat
- FEAT_WIDTH, 8, feature/weight element width
- PE_OUT_WIDTH, 8, per-column sum width
- SPAD_WIDTH, 64, elements per data_bus beat
- PE_DIM, 16, PE columns in the row
- ADDR_WIDTH, C_LOG_2(SPAD_WIDTH), non-zero address width
- LOG_PE_DIM, C_LOG_2(PE_DIM), column index width

- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low
- wgt_valid / wgt_ready  in/out  1  weight-vector handshake
- wgt_data  in  FEAT_WIDTH*SPAD_WIDTH  weight vector for the next column
- feat_valid / feat_ready  in/out  1  feature-beat handshake
- feat_data  in  FEAT_WIDTH*SPAD_WIDTH  feature beat
- feat_addr  in  ADDR_WIDTH*MAC_DIM  non-zero addresses
- feat_nz  in  3  non-zero count for the beat
- feat_last  in  1  marks the final beat of the job
- reuse_wgt  in  1  sampled at result accept: 1 keeps the loaded weights
- data_bus  out  FEAT_WIDTH*SPAD_WIDTH  to row data_bus
- non_zero_add_bus  out  ADDR_WIDTH*MAC_DIM  to row
- non_zero_num  out  3  to row
- weight_enable_top  out  LOG_PE_DIM  target column
- broad_cast_enable, acc, done, psum_rd  out  1  row controls
- sum_out_bus  in  PE_OUT_WIDTH*PE_DIM  row sums
- out_vd  in  PE_DIM  per-column valid
- res_valid / res_ready  out/in  1  result handshake
- res_data  out  PE_OUT_WIDTH*PE_DIM  captured sums
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WLOAD, FEED, DONE, WAIT_VD, DRAIN.
- **IDLE**
  - Goes to WLOAD when wgt_valid=1.
  - Goes to FEED when feat_valid=1 and the internal wgt_loaded flag is set.
- **WLOAD**
  - wgt_ready=1.
  - Each accepted beat drives data_bus=wgt_data and weight_enable_top=col_cnt for one cycle; col_cnt then increments.
  - After beat PE_DIM-1: set wgt_loaded, clear col_cnt, go to FEED.
- **FEED**
  - feat_ready=1.
  - Each accepted beat with feat_nz≠0 drives data_bus, non_zero_add_bus, non_zero_num, broad_cast_enable=1 and acc=1 for one cycle.
  - feat_nz>MAC_DIM is clamped to MAC_DIM.
  - feat_nz=0 beats are consumed and dropped: no broadcast, no acc.
  - An accepted beat with feat_last=1 moves to DONE, whether or not it had non-zeros.
- **DONE**
  - done=1 for exactly one cycle.
  - Clears the vd_seen mask, then goes to WAIT_VD.
- **WAIT_VD**
  - For each column i with out_vd[i]=1, latch sum_out_bus lane i into res_data lane i and set vd_seen[i].
  - Repeated valids on the same column overwrite that lane.
  - When vd_seen becomes all-ones: psum_rd=1 for one cycle, go to DRAIN.
  - out_vd outside WAIT_VD is ignored.
- **DRAIN**
  - res_valid=1; res_data is held stable until res_ready=1.
  - On accept: reuse_wgt=1 goes to IDLE with wgt_loaded kept; otherwise wgt_loaded is cleared and the state goes to IDLE.
- **Outputs and reset**
  - All row outputs are registered. Every 1-bit output, weight_enable_top and non_zero_num are 0 in every cycle they are not being driven.
  - data_bus and the address bus hold their last value.
  - Reset (any cycle, including mid-job): state=IDLE; all outputs, col_cnt, vd_seen, wgt_loaded and res_data are 0.

## Timing
- A handshake accepted at edge t appears on the row outputs during cycle t+1. Throughput is one beat per cycle.
- done is asserted in the cycle after the last beat's acc cycle. If the last beat has nz=0, done is asserted in the cycle after that beat is accepted.
- vd_seen completing at edge t gives psum_rd=1 in cycle t+1 and res_valid=1 from cycle t+2.
- res_valid with res_ready already high is accepted on the first edge; the state is IDLE the next cycle.
- wgt_ready and feat_ready are never high simultaneously. Both are low in DONE, WAIT_VD and DRAIN.

## Test plan
- **Reset values:** reset low mid-FEED after 3 beats → all outputs 0 next cycle; after release, busy=0 and feat_ready=0 even with feat_valid=1 (wgt_loaded cleared).
- **Weight load:** 16 wgt beats with wgt_data=i → weight_enable_top steps 0..15 on consecutive cycles; the state is FEED on the cycle after the 16th accept.
- **Feature feed:** 4 feature beats with feat_nz=3,0,7,2 (last on the 4th) → exactly 3 acc pulses with non_zero_num=3,6,2, then one done pulse.
- **Out-of-order valids:** out_vd bits arrive out of order over 5 cycles, lane i sum=i+1 → psum_rd single pulse after the final bit; res_data lane i=i+1; res_valid held until res_ready.
- **Weight reuse:** reuse_wgt=1 at accept, then new feat_valid → goes straight to FEED with no wgt_ready. With reuse_wgt=0 → feat_valid is ignored until 16 new weights load.
- **Stray valid:** out_vd=all-ones during FEED → ignored; WAIT_VD still waits for fresh valids after done.

Source files
------------

// File: rtl/pe_row_feeder.sv
// pe_row_feeder: loads PE_DIM weight vectors, broadcasts feature beats to a
// PE row, then gathers per-column sums and hands them out over res_valid/ready.
// Ports:
//   clk, reset (async, active-low)
//   wgt_*  : weight-vector handshake in
//   feat_* : feature-beat handshake in
//   data_bus, non_zero_add_bus, non_zero_num, weight_enable_top,
//   broad_cast_enable, acc, done, psum_rd : registered row controls out
//   sum_out_bus, out_vd : row results in
//   res_valid/res_ready/res_data : result handshake out
//   busy : high outside IDLE
module pe_row_feeder #(
  parameter int MAC_DIM      = 6,
  parameter int FEAT_WIDTH   = 8,
  parameter int PE_OUT_WIDTH = 8,
  parameter int SPAD_WIDTH   = 64,
  parameter int PE_DIM       = 16,
  parameter int ADDR_WIDTH   = $clog2(SPAD_WIDTH),
  parameter int LOG_PE_DIM   = $clog2(PE_DIM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wgt_valid,
  output logic                         wgt_ready,
  input  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] wgt_data,
  input  logic                         feat_valid,
  output logic                         feat_ready,
  input  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] feat_data,
  input  logic [ADDR_WIDTH*MAC_DIM-1:0]    feat_addr,
  input  logic [2:0]                   feat_nz,
  input  logic                         feat_last,
  input  logic                         reuse_wgt,
  output logic [FEAT_WIDTH*SPAD_WIDTH-1:0] data_bus,
  output logic [ADDR_WIDTH*MAC_DIM-1:0]    non_zero_add_bus,
  output logic [2:0]                   non_zero_num,
  output logic [LOG_PE_DIM-1:0]        weight_enable_top,
  output logic                         broad_cast_enable,
  output logic                         acc,
  output logic                         done,
  output logic                         psum_rd,
  input  logic [PE_OUT_WIDTH*PE_DIM-1:0]   sum_out_bus,
  input  logic [PE_DIM-1:0]            out_vd,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [PE_OUT_WIDTH*PE_DIM-1:0]   res_data,
  output logic                         busy
);

  localparam int DW = FEAT_WIDTH*SPAD_WIDTH;
  localparam int AW = ADDR_WIDTH*MAC_DIM;
  localparam int RW = PE_OUT_WIDTH*PE_DIM;
  localparam logic [2:0] NZ_MAX = 3'(MAC_DIM);
  localparam logic [LOG_PE_DIM-1:0] COL_LAST =
    LOG_PE_DIM'(PE_DIM-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_FEED,
    S_DONE,
    S_WAIT_VD,
    S_DRAIN
  } state_t;

  state_t state, state_d;

  logic [LOG_PE_DIM-1:0] col_cnt, col_cnt_d;
  logic                  wgt_loaded, wgt_loaded_d;
  logic [PE_DIM-1:0]     vd_seen, vd_seen_d;

  logic [DW-1:0]         data_d;
  logic [AW-1:0]         addr_d;
  logic [2:0]            nzn_d;
  logic [LOG_PE_DIM-1:0] wen_d;
  logic                  bce_d, acc_d, done_d;
  logic                  psum_d, rv_d;
  logic [RW-1:0]         res_d;

  logic wgt_acc, feat_acc, res_acc;
  logic vd_full;
  logic [2:0] nz_clamp;

  assign wgt_ready  = (state == S_WLOAD);
  assign feat_ready = (state == S_FEED);
  assign busy       = (state != S_IDLE);

  assign wgt_acc  = wgt_valid & wgt_ready;
  assign feat_acc = feat_valid & feat_ready;
  assign res_acc  = res_valid & res_ready;
  assign vd_full  = &(vd_seen | out_vd);
  assign nz_clamp = (feat_nz > NZ_MAX) ? NZ_MAX : feat_nz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (wgt_valid)
          state_d = S_WLOAD;
        else if (feat_valid && wgt_loaded)
          state_d = S_FEED;
      end
      S_WLOAD: begin
        if (wgt_acc && col_cnt == COL_LAST)
          state_d = S_FEED;
      end
      S_FEED: begin
        if (feat_acc && feat_last)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_WAIT_VD;
      S_WAIT_VD: begin
        if (vd_full) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_acc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d       = data_bus;
    addr_d       = non_zero_add_bus;
    nzn_d        = '0;
    wen_d        = '0;
    bce_d        = 1'b0;
    acc_d        = 1'b0;
    done_d       = 1'b0;
    psum_d       = 1'b0;
    rv_d         = 1'b0;
    res_d        = res_data;
    col_cnt_d    = col_cnt;
    wgt_loaded_d = wgt_loaded;
    vd_seen_d    = vd_seen;
    unique case (state)
      S_WLOAD: begin
        if (wgt_acc) begin
          data_d = wgt_data;
          wen_d  = col_cnt;
          if (col_cnt == COL_LAST) begin
            col_cnt_d    = '0;
            wgt_loaded_d = 1'b1;
          end else begin
            col_cnt_d = col_cnt + 1'b1;
          end
        end
      end
      S_FEED: begin
        if (feat_acc) begin
          if (feat_nz != 3'd0) begin
            data_d = feat_data;
            addr_d = feat_addr;
            nzn_d  = nz_clamp;
            bce_d  = 1'b1;
            acc_d  = 1'b1;
          end else if (feat_last) begin
            // no acc cycle to wait behind
            done_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        // pulse now unless it already fired on an empty last beat
        done_d    = ~done;
        vd_seen_d = '0;
      end
      S_WAIT_VD: begin
        for (int i = 0; i < PE_DIM; i++) begin
          if (out_vd[i]) begin
            res_d[i*PE_OUT_WIDTH +: PE_OUT_WIDTH] =
              sum_out_bus[i*PE_OUT_WIDTH +: PE_OUT_WIDTH];
            vd_seen_d[i] = 1'b1;
          end
        end
        psum_d = vd_full;
      end
      S_DRAIN: begin
        rv_d = ~res_acc;
        if (res_acc && !reuse_wgt)
          wgt_loaded_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_bus          <= '0;
      non_zero_add_bus  <= '0;
      non_zero_num      <= '0;
      weight_enable_top <= '0;
      broad_cast_enable <= 1'b0;
      acc               <= 1'b0;
      done              <= 1'b0;
      psum_rd           <= 1'b0;
      res_valid         <= 1'b0;
      res_data          <= '0;
      col_cnt           <= '0;
      wgt_loaded        <= 1'b0;
      vd_seen           <= '0;
    end else begin
      data_bus          <= data_d;
      non_zero_add_bus  <= addr_d;
      non_zero_num      <= nzn_d;
      weight_enable_top <= wen_d;
      broad_cast_enable <= bce_d;
      acc               <= acc_d;
      done              <= done_d;
      psum_rd           <= psum_d;
      res_valid         <= rv_d;
      res_data          <= res_d;
      col_cnt           <= col_cnt_d;
      wgt_loaded        <= wgt_loaded_d;
      vd_seen           <= vd_seen_d;
    end
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// tb_pe_row_feeder: random jobs against a queue/array model of the feeder.
// Drives and samples on the falling edge.
module tb_pe_row_feeder;

  localparam logic [511:0] ONE  = 512'd1;
  localparam logic [511:0] ZERO = 512'd0;

  logic         clk = 1'b0;
  logic         reset;
  logic         wgt_valid, wgt_ready;
  logic [511:0] wgt_data;
  logic         feat_valid, feat_ready;
  logic [511:0] feat_data;
  logic [35:0]  feat_addr;
  logic [2:0]   feat_nz;
  logic         feat_last, reuse_wgt;
  logic [511:0] data_bus;
  logic [35:0]  non_zero_add_bus;
  logic [2:0]   non_zero_num;
  logic [3:0]   weight_enable_top;
  logic         broad_cast_enable, acc, done, psum_rd;
  logic [127:0] sum_out_bus;
  logic [15:0]  out_vd;
  logic         res_valid, res_ready;
  logic [127:0] res_data;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_row_feeder dut (
    .clk               (clk),
    .reset             (reset),
    .wgt_valid         (wgt_valid),
    .wgt_ready         (wgt_ready),
    .wgt_data          (wgt_data),
    .feat_valid        (feat_valid),
    .feat_ready        (feat_ready),
    .feat_data         (feat_data),
    .feat_addr         (feat_addr),
    .feat_nz           (feat_nz),
    .feat_last         (feat_last),
    .reuse_wgt         (reuse_wgt),
    .data_bus          (data_bus),
    .non_zero_add_bus  (non_zero_add_bus),
    .non_zero_num      (non_zero_num),
    .weight_enable_top (weight_enable_top),
    .broad_cast_enable (broad_cast_enable),
    .acc               (acc),
    .done              (done),
    .psum_rd           (psum_rd),
    .sum_out_bus       (sum_out_bus),
    .out_vd            (out_vd),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data          (res_data),
    .busy              (busy)
  );

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [511:0] rnd_data();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] rnd_sums();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [2:0] clamp_nz(input logic [2:0] n);
    return (n > 3'd6) ? 3'd6 : n;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, data_bus, ZERO);
    chk({tag, "_addr"}, 512'(non_zero_add_bus), ZERO);
    chk({tag, "_nzn"}, 512'(non_zero_num), ZERO);
    chk({tag, "_wen"}, 512'(weight_enable_top), ZERO);
    chk({tag, "_bce"}, 512'(broad_cast_enable), ZERO);
    chk({tag, "_acc"}, 512'(acc), ZERO);
    chk({tag, "_done"}, 512'(done), ZERO);
    chk({tag, "_psum"}, 512'(psum_rd), ZERO);
    chk({tag, "_rv"}, 512'(res_valid), ZERO);
    chk({tag, "_res"}, 512'(res_data), ZERO);
    chk({tag, "_busy"}, 512'(busy), ZERO);
    chk({tag, "_wrdy"}, 512'(wgt_ready), ZERO);
    chk({tag, "_frdy"}, 512'(feat_ready), ZERO);
  endtask

  task automatic load_weights(input bit directed);
    logic [511:0] wcur;
    int k, guard;
    bit took;
    k = 0;
    guard = 0;
    feat_valid = 1'b0;
    while (k < 16 && guard < 200) begin
      wgt_valid = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      wcur = directed ? 512'(k) : rnd_data();
      wgt_data = wcur;
      took = wgt_valid && wgt_ready;
      tick();
      guard++;
      if (took) begin
        chk("w_col", 512'(weight_enable_top), 512'(k));
        chk("w_data", data_bus, wcur);
        chk("w_acc", 512'(acc), ZERO);
        k++;
      end else begin
        chk("w_col_idle", 512'(weight_enable_top), ZERO);
      end
    end
    wgt_valid = 1'b0;
    if (k < 16) chk("w_timeout", 512'(k), 512'(16));
    chk("w_feed_rdy", 512'(feat_ready), ONE);
    chk("w_wrdy_low", 512'(wgt_ready), ZERO);
  endtask

  task automatic run_job(input bit directed, input bit force_reuse,
                         output bit reuse);
    logic [511:0] fd[8];
    logic [35:0]  fa[8];
    logic [2:0]   fn[8];
    logic [7:0]   exp_lane[16];
    logic [127:0] exp_res, sums;
    logic [15:0]  seen, mask;
    int perm[16];
    int n, k, guard, nacc, exp_acc, pos, pos0, take, h, j, tmp;
    bit took, complete;

    n = directed ? 4 : $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      fd[i] = rnd_data();
      fa[i] = 36'({$urandom, $urandom});
      if (directed)
        fn[i] = (i == 0) ? 3'd3 : (i == 1) ? 3'd0 :
                (i == 2) ? 3'd7 : 3'd2;
      else
        fn[i] = 3'($urandom_range(0, 7));
    end

    // feature phase, with stray out_vd noise the row must ignore
    k = 0; guard = 0; nacc = 0; exp_acc = 0;
    while (k < n && guard < 300) begin
      feat_valid = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      feat_data = fd[k];
      feat_addr = fa[k];
      feat_nz = fn[k];
      feat_last = (k == n - 1);
      out_vd = ($urandom_range(0, 1) == 1) ? 16'hffff : 16'($urandom);
      sum_out_bus = rnd_sums();
      took = feat_valid && feat_ready;
      tick();
      guard++;
      nacc += int'(acc);
      if (took) begin
        if (fn[k] != 3'd0) begin
          exp_acc++;
          chk("f_acc", 512'(acc), ONE);
          chk("f_bce", 512'(broad_cast_enable), ONE);
          chk("f_nzn", 512'(non_zero_num), 512'(clamp_nz(fn[k])));
          chk("f_data", data_bus, fd[k]);
          chk("f_addr", 512'(non_zero_add_bus), 512'(fa[k]));
        end else begin
          chk("f_drop_acc", 512'(acc), ZERO);
          chk("f_drop_nzn", 512'(non_zero_num), ZERO);
        end
        k++;
      end else begin
        chk("f_idle_acc", 512'(acc), ZERO);
        chk("f_idle_nzn", 512'(non_zero_num), ZERO);
      end
      if (k < n) chk("f_done_early", 512'(done), ZERO);
    end
    feat_valid = 1'b0;
    feat_last = 1'b0;
    if (k < n) chk("f_timeout", 512'(k), 512'(n));

    chk("done_t1", 512'(done), 512'(fn[n-1] == 3'd0));
    chk("frdy_done", 512'(feat_ready), ZERO);
    out_vd = 16'hffff;
    tick();
    chk("done_t2", 512'(done), 512'(fn[n-1] != 3'd0));
    chk("acc_after", 512'(acc), ZERO);
    chk("acc_count", 512'(nacc), 512'(exp_acc));

    // column results arrive out of order, with repeats
    for (int i = 0; i < 16; i++) begin
      perm[i] = i;
      exp_lane[i] = 8'h00;
    end
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    seen = '0; pos = 0; guard = 0; complete = 1'b0;
    while (!complete && guard < 100) begin
      mask = '0;
      pos0 = pos;
      take = $urandom_range(0, 4);
      for (int t = 0; t < take && pos < 16; t++) begin
        mask[perm[pos]] = 1'b1;
        pos++;
      end
      if (pos0 > 0 && $urandom_range(0, 2) == 0)
        mask[perm[$urandom_range(0, pos0 - 1)]] = 1'b1;
      sums = rnd_sums();
      for (int i = 0; i < 16; i++) begin
        if (directed) sums[i*8 +: 8] = 8'(i + 1);
        if (mask[i]) exp_lane[i] = sums[i*8 +: 8];
      end
      seen |= mask;
      complete = (seen == 16'hffff);
      out_vd = mask;
      sum_out_bus = sums;
      tick();
      guard++;
      chk("psum", 512'(psum_rd), 512'(complete));
      chk("rv_wait", 512'(res_valid), ZERO);
    end
    if (!complete) chk("vd_timeout", 512'(seen), 512'(16'hffff));
    for (int i = 0; i < 16; i++) exp_res[i*8 +: 8] = exp_lane[i];

    out_vd = '0;
    tick();
    chk("psum_single", 512'(psum_rd), ZERO);
    chk("rv_rise", 512'(res_valid), ONE);
    chk("res_data", 512'(res_data), 512'(exp_res));

    reuse = force_reuse ? 1'b1 : 1'($urandom_range(0, 1));
    h = $urandom_range(0, 3);
    for (int i = 0; i < h; i++) begin
      out_vd = 16'($urandom);
      sum_out_bus = rnd_sums();
      tick();
      chk("rv_hold", 512'(res_valid), ONE);
      chk("res_hold", 512'(res_data), 512'(exp_res));
      chk("busy_drain", 512'(busy), ONE);
    end
    out_vd = '0;
    res_ready = 1'b1;
    reuse_wgt = reuse;
    tick();
    res_ready = 1'b0;
    reuse_wgt = 1'b0;
    chk("rv_drop", 512'(res_valid), ZERO);
    chk("idle_busy", 512'(busy), ZERO);
  endtask

  task automatic begin_job(input bit reuse);
    wgt_valid = 1'b0;
    feat_valid = 1'b1;
    if (reuse) begin
      tick();
      chk("reuse_frdy", 512'(feat_ready), ONE);
      chk("reuse_wrdy", 512'(wgt_ready), ZERO);
      feat_valid = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("noreuse_frdy", 512'(feat_ready), ZERO);
        chk("noreuse_busy", 512'(busy), ZERO);
      end
      feat_valid = 1'b0;
      load_weights(1'b0);
    end
  endtask

  task automatic reset_test();
    int got, guard;
    bit took;
    got = 0;
    guard = 0;
    feat_last = 1'b0;
    feat_valid = 1'b1;
    while (got < 3 && guard < 50) begin
      feat_data = rnd_data();
      feat_addr = 36'({$urandom, $urandom});
      feat_nz = 3'($urandom_range(1, 7));
      took = feat_ready;
      tick();
      guard++;
      if (took) got++;
    end
    chk("rst_pre_acc", 512'(acc), ONE);
    reset = 1'b0;
    #1;
    check_zero("rst_now");
    @(negedge clk);
    check_zero("rst_next");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", 512'(busy), ZERO);
      chk("rst_frdy", 512'(feat_ready), ZERO);
    end
    feat_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    reset = 1'b0;
    wgt_valid = 1'b0;
    wgt_data = '0;
    feat_valid = 1'b0;
    feat_data = '0;
    feat_addr = '0;
    feat_nz = '0;
    feat_last = 1'b0;
    reuse_wgt = 1'b0;
    sum_out_bus = '0;
    out_vd = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    tick();
    chk("post_rst_busy", 512'(busy), ZERO);

    load_weights(1'b1);
    run_job(1'b1, 1'b1, r);
    feat_valid = 1'b1;
    tick();
    chk("reuse_first", 512'(feat_ready), ONE);
    reset_test();

    load_weights(1'b0);
    for (int j = 0; j < 8; j++) begin
      run_job(1'b0, 1'b0, r);
      begin_job(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
